// File: rtl/cmt_cnt_pkg.sv
// Compare-match timer shared definitions.
// Clock-select encodings, divisor limits and default widths.
package cmt_cnt_pkg;

  localparam int CMT_CW = 16;
  localparam int CMT_PW = 9;

  typedef enum logic [1:0] {
    CKS_DIV8   = 2'd0,
    CKS_DIV32  = 2'd1,
    CKS_DIV128 = 2'd2,
    CKS_DIV512 = 2'd3
  } cks_e;

  localparam logic [CMT_PW-1:0] CMT_DL8   = 9'd7;
  localparam logic [CMT_PW-1:0] CMT_DL32  = 9'd31;
  localparam logic [CMT_PW-1:0] CMT_DL128 = 9'd127;
  localparam logic [CMT_PW-1:0] CMT_DL512 = 9'd511;

  function automatic logic [CMT_PW-1:0] cmt_dl(
    input logic [1:0] cks
  );
    logic [CMT_PW-1:0] dl;
    dl = CMT_DL512;
    unique case (cks)
      CKS_DIV8:   dl = CMT_DL8;
      CKS_DIV32:  dl = CMT_DL32;
      CKS_DIV128: dl = CMT_DL128;
      CKS_DIV512: dl = CMT_DL512;
      default:    dl = CMT_DL512;
    endcase
    return dl;
  endfunction

endpackage

// File: rtl/cmt_cnt_chn.sv
// One compare-match timer channel:
// prescaler, up-counter and sticky match flag.
module cmt_chn
  import cmt_cnt_pkg::*;
#(
  parameter int CW = CMT_CW,
  parameter int PW = CMT_PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          str,
  input  logic [1:0]    cks,
  input  logic [CW-1:0] cmp,
  input  logic          set_cnt,
  input  logic [CW-1:0] wdata,
  input  logic          clr_cmf,
  output logic [CW-1:0] cnt,
  output logic          cmf
);

  logic [PW-1:0] presc;
  logic [PW-1:0] dl;
  logic          tick;
  logic          match;

  assign dl = PW'(cmt_dl(cks));

  // >= so a shrinking divisor never strands presc above the limit
  assign tick  = str && (presc >= dl);
  assign match = tick && !set_cnt && (cnt == cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (!str || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (set_cnt) begin
      cnt <= wdata;
    end else if (match) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmf <= 1'b0;
    end else if (match) begin
      cmf <= 1'b1;
    end else if (clr_cmf) begin
      cmf <= 1'b0;
    end
  end

endmodule

// File: rtl/cmt_cnt.sv
// Two-channel compare-match timer counter core.
// Pure wiring around two independent channels.
module cmt_cnt
  import cmt_cnt_pkg::*;
#(
  parameter int CW = CMT_CW,
  parameter int PW = CMT_PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          str0_i,
  input  logic          str1_i,
  input  logic [1:0]    cks0_i,
  input  logic [1:0]    cks1_i,
  input  logic [CW-1:0] const0_i,
  input  logic [CW-1:0] const1_i,
  input  logic          set_cnt0_i,
  input  logic [CW-1:0] wdata_cnt0_i,
  input  logic          set_cnt1_i,
  input  logic [CW-1:0] wdata_cnt1_i,
  input  logic          clr_cmf0_i,
  input  logic          clr_cmf1_i,
  output logic [CW-1:0] cnt0_o,
  output logic [CW-1:0] cnt1_o,
  output logic          cmf0_o,
  output logic          cmf1_o
);

  cmt_chn #(
    .CW(CW),
    .PW(PW)
  ) u_chn0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .str     (str0_i),
    .cks     (cks0_i),
    .cmp     (const0_i),
    .set_cnt (set_cnt0_i),
    .wdata   (wdata_cnt0_i),
    .clr_cmf (clr_cmf0_i),
    .cnt     (cnt0_o),
    .cmf     (cmf0_o)
  );

  cmt_chn #(
    .CW(CW),
    .PW(PW)
  ) u_chn1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .str     (str1_i),
    .cks     (cks1_i),
    .cmp     (const1_i),
    .set_cnt (set_cnt1_i),
    .wdata   (wdata_cnt1_i),
    .clr_cmf (clr_cmf1_i),
    .cnt     (cnt1_o),
    .cmf     (cmf1_o)
  );

endmodule

// File: tb/tb_cmt_cnt.sv
// Directed bench for the two-channel compare-match timer.
// Inputs change and outputs are sampled on the falling edge.
module tb_cmt_cnt;

  logic        clk;
  logic        rst_n;
  logic        str0, str1;
  logic [1:0]  cks0, cks1;
  logic [15:0] const0, const1;
  logic        set0, set1;
  logic [15:0] wd0, wd1;
  logic        clr0, clr1;
  logic [15:0] cnt0, cnt1;
  logic        cmf0, cmf1;

  int total;
  int bad;

  cmt_cnt dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .str0_i       (str0),
    .str1_i       (str1),
    .cks0_i       (cks0),
    .cks1_i       (cks1),
    .const0_i     (const0),
    .const1_i     (const1),
    .set_cnt0_i   (set0),
    .wdata_cnt0_i (wd0),
    .set_cnt1_i   (set1),
    .wdata_cnt1_i (wd1),
    .clr_cmf0_i   (clr0),
    .clr_cmf1_i   (clr1),
    .cnt0_o       (cnt0),
    .cnt1_o       (cnt1),
    .cmf0_o       (cmf0),
    .cmf1_o       (cmf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    total++;
    if ({cnt0, cnt1, cmf0, cmf1} !== 34'd0) begin
      bad++;
      $display("FAIL reset got=%h want=0",
               {cnt0, cnt1, cmf0, cmf1});
    end
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_count();
    logic [15:0] e;
    str0 = 1'b1;
    cks0 = 2'd0;
    const0 = 16'd3;
    for (int k = 1; k <= 4; k++) begin
      cyc(7);
      e = (k == 1) ? 16'd0 : 16'(k - 1);
      total++;
      if (cnt0 !== e) begin
        bad++;
        $display("FAIL pre_tick%0d got=%h want=%h", k, cnt0, e);
      end
      cyc(1);
      e = (k < 4) ? 16'(k) : 16'd0;
      total++;
      if (cnt0 !== e || cmf0 !== (k == 4)) begin
        bad++;
        $display("FAIL tick%0d got=%h/%b want=%h/%b",
                 k, cnt0, cmf0, e, k == 4);
      end
    end
    total++;
    if (cnt1 !== 16'd0 || cmf1 !== 1'b0) begin
      bad++;
      $display("FAIL ch1_idle got=%h/%b want=0/0", cnt1, cmf1);
    end
  endtask

  task automatic test_cmf_clear();
    cyc(31);
    clr0 = 1'b1;
    cyc(1);
    clr0 = 1'b0;
    total++;
    if (cmf0 !== 1'b1 || cnt0 !== 16'd0) begin
      bad++;
      $display("FAIL set_wins got=%h/%b want=0/1", cnt0, cmf0);
    end
    clr0 = 1'b1;
    cyc(1);
    clr0 = 1'b0;
    total++;
    if (cmf0 !== 1'b0) begin
      bad++;
      $display("FAIL clr got=%b want=0", cmf0);
    end
    str0 = 1'b0;
    cyc(1);
  endtask

  task automatic test_wrap();
    logic [15:0] exp_v [8];
    exp_v = '{16'hFFFF, 16'h0, 16'h1, 16'h2,
              16'h3, 16'h4, 16'h5, 16'h0};
    set0 = 1'b1;
    wd0 = 16'hFFFE;
    const0 = 16'd5;
    cks0 = 2'd0;
    cyc(1);
    set0 = 1'b0;
    str0 = 1'b1;
    total++;
    if (cnt0 !== 16'hFFFE) begin
      bad++;
      $display("FAIL load got=%h want=fffe", cnt0);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(8);
      total++;
      if (cnt0 !== exp_v[i] || cmf0 !== (i == 7)) begin
        bad++;
        $display("FAIL wrap%0d got=%h/%b want=%h/%b",
                 i, cnt0, cmf0, exp_v[i], i == 7);
      end
    end
    cyc(7);
    set0 = 1'b1;
    wd0 = 16'h1234;
    cyc(1);
    set0 = 1'b0;
    total++;
    if (cnt0 !== 16'h1234) begin
      bad++;
      $display("FAIL load_on_tick got=%h want=1234", cnt0);
    end
    cyc(8);
    total++;
    if (cnt0 !== 16'h1235) begin
      bad++;
      $display("FAIL after_load got=%h want=1235", cnt0);
    end
    str0 = 1'b0;
    clr0 = 1'b1;
    cyc(1);
    clr0 = 1'b0;
  endtask

  task automatic test_cks_switch();
    str1 = 1'b1;
    cks1 = 2'd3;
    const1 = 16'hFFFF;
    cyc(200);
    cks1 = 2'd0;
    total++;
    if (cnt1 !== 16'd0) begin
      bad++;
      $display("FAIL slow_presc got=%h want=0", cnt1);
    end
    cyc(1);
    total++;
    if (cnt1 !== 16'd1) begin
      bad++;
      $display("FAIL switch_tick got=%h want=1", cnt1);
    end
    cyc(7);
    total++;
    if (cnt1 !== 16'd1) begin
      bad++;
      $display("FAIL switch_hold got=%h want=1", cnt1);
    end
    cyc(1);
    total++;
    if (cnt1 !== 16'd2) begin
      bad++;
      $display("FAIL switch_t2 got=%h want=2", cnt1);
    end
    cyc(8);
    total++;
    if (cnt1 !== 16'd3) begin
      bad++;
      $display("FAIL switch_t3 got=%h want=3", cnt1);
    end
  endtask

  task automatic test_stop_restart();
    set0 = 1'b1;
    wd0 = 16'h000F;
    const0 = 16'hFFFF;
    cks0 = 2'd0;
    cyc(1);
    set0 = 1'b0;
    str0 = 1'b1;
    cyc(8);
    total++;
    if (cnt0 !== 16'h0010) begin
      bad++;
      $display("FAIL reach10 got=%h want=0010", cnt0);
    end
    cyc(4);
    str0 = 1'b0;
    cyc(100);
    total++;
    if (cnt0 !== 16'h0010 || cmf0 !== 1'b0) begin
      bad++;
      $display("FAIL stopped got=%h/%b want=0010/0", cnt0, cmf0);
    end
    str0 = 1'b1;
    cyc(7);
    total++;
    if (cnt0 !== 16'h0010) begin
      bad++;
      $display("FAIL restart7 got=%h want=0010", cnt0);
    end
    cyc(1);
    total++;
    if (cnt0 !== 16'h0011) begin
      bad++;
      $display("FAIL restart8 got=%h want=0011", cnt0);
    end
  endtask

  task automatic test_async_reset();
    const0 = 16'h0011;
    cyc(8);
    total++;
    if (cmf0 !== 1'b1 || cnt0 !== 16'd0) begin
      bad++;
      $display("FAIL pre_rst got=%h/%b want=0/1", cnt0, cmf0);
    end
    cyc(3);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({cnt0, cnt1, cmf0, cmf1} !== 34'd0) begin
      bad++;
      $display("FAIL async_rst got=%h want=0",
               {cnt0, cnt1, cmf0, cmf1});
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(7);
    total++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      bad++;
      $display("FAIL post_rst7 got=%h/%h want=0/0", cnt0, cnt1);
    end
    cyc(1);
    total++;
    if (cnt0 !== 16'd1 || cnt1 !== 16'd1) begin
      bad++;
      $display("FAIL post_rst8 got=%h/%h want=1/1", cnt0, cnt1);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    str0 = 1'b0;
    str1 = 1'b0;
    cks0 = 2'd0;
    cks1 = 2'd0;
    const0 = 16'd0;
    const1 = 16'd0;
    set0 = 1'b0;
    set1 = 1'b0;
    wd0 = 16'd0;
    wd1 = 16'd0;
    clr0 = 1'b0;
    clr1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_count();
    test_cmf_clear();
    test_wrap();
    test_cks_switch();
    test_stop_restart();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
